uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud divisor math.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int uart_div(input int f, input int baud);
    return f / baud;
  endfunction

  function automatic int uart_half(input int f, input int baud);
    return (f / baud) / 2;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half a bit, mid-bit sampling of data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);

  localparam int DIV   = uart_div(F, BAUD);
  localparam int HALF  = uart_half(F, BAUD);
  localparam int CNT_W = $clog2(DIV);

  generate
    if (DIV < 4) begin : g_bad_div
      $error("uart_rx: F/BAUD must be at least 4");
    end
  endgenerate

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);

  logic rxs;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             tick_half, tick_full;

  assign tick_half = (cnt_q == HALF_M1);
  assign tick_full = (cnt_q == DIV_M1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        // A start bit that is gone by its midpoint is treated as a line glitch.
        if (tick_half) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (tick_full) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop-bit lets a following start edge be caught with no idle gap.
        if (tick_full) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one instance at default rates, one with a short divisor.
module tb_uart_rx;

  localparam int DIV_A  = 50000000 / 115200;
  localparam int HALF_A = DIV_A / 2;
  localparam int LAT_A  = 2 + HALF_A + 9 * DIV_A;
  localparam int F_B    = 1600;
  localparam int BAUD_B = 100;
  localparam int DIV_B  = F_B / BAUD_B;
  localparam int HALF_B = DIV_B / 2;
  localparam int LAT_B  = 2 + HALF_B + 9 * DIV_B;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    int         t_fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_valid_a = 0, n_ferr_a = 0, n_valid_b = 0, n_ferr_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   vt_a[$];
  logic [7:0] last_good [2];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx u_dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .rx    (rx_a),
    .data  (data_a),
    .valid (valid_a),
    .ferr  (ferr_a),
    .busy  (busy_a)
  );

  uart_rx #(.BAUD(BAUD_B), .F(F_B)) u_dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .rx    (rx_b),
    .data  (data_b),
    .valid (valid_b),
    .ferr  (ferr_b),
    .busy  (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Serial transmitter model; call just after a falling clock edge.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int div);
    exp_t e;
    logic bitv;
    e.t_fall  = cyc;
    e.is_ferr = !stop;
    if (stop) last_good[sel] = b;
    e.data    = last_good[sel];
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    for (int i = 0; i < 10; i++) begin
      bitv = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      set_rx(sel, bitv);
      repeat (div) @(negedge clk);
    end
    set_rx(sel, 1'b1);
  endtask

  always @(negedge clk) begin
    if (valid_a || ferr_a) begin
      check("excl_a", {31'b0, valid_a & ferr_a}, 32'd0);
      if (valid_a) begin
        n_valid_a++;
        vt_a.push_back(cyc);
      end else begin
        n_ferr_a++;
      end
      check("sb_a_pending", {31'b0, q_a.size() > 0}, 32'd1);
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        check("kind_a", {31'b0, ferr_a}, {31'b0, ea.is_ferr});
        check("data_a", {24'b0, data_a}, {24'b0, ea.data});
        if (ea.t_fall >= 0)
          check($sformatf("lat_a(d=%0d)", cyc - ea.t_fall),
                {31'b0, (cyc - ea.t_fall >= LAT_A - 1) && (cyc - ea.t_fall <= LAT_A + 1)}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b || ferr_b) begin
      check("excl_b", {31'b0, valid_b & ferr_b}, 32'd0);
      if (valid_b) n_valid_b++;
      else         n_ferr_b++;
      check("sb_b_pending", {31'b0, q_b.size() > 0}, 32'd1);
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        check("kind_b", {31'b0, ferr_b}, {31'b0, eb.is_ferr});
        check("data_b", {24'b0, data_b}, {24'b0, eb.data});
        if (eb.t_fall >= 0)
          check($sformatf("lat_b(d=%0d)", cyc - eb.t_fall),
                {31'b0, (cyc - eb.t_fall >= LAT_B - 1) && (cyc - eb.t_fall <= LAT_B + 1)}, 32'd1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pb;
    exp_t eb0;
    int   n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_data_a",  {24'b0, data_a}, 32'h00);
    check("rst_valid_a", {31'b0, valid_a}, 32'd0);
    check("rst_ferr_a",  {31'b0, ferr_a}, 32'd0);
    check("rst_busy_a",  {31'b0, busy_a}, 32'd0);
    check("rst_data_b",  {24'b0, data_b}, 32'h00);
    check("rst_busy_b",  {31'b0, busy_b}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy_a", {31'b0, busy_a}, 32'd0);

    // Good frame at default rates.
    send_frame(1'b0, 8'hA5, 1'b1, DIV_A);
    repeat (20) @(negedge clk);
    check("a5_data", {24'b0, data_a}, 32'hA5);
    check("a5_busy", {31'b0, busy_a}, 32'd0);

    // Short low pulse: start bit rejected at its midpoint.
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    check("glitch_busy_hi", {31'b0, busy_a}, 32'd1);
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (140) @(negedge clk);
    check("glitch_busy_lo", {31'b0, busy_a}, 32'd0);

    // Stop bit low: framing error, data retained.
    send_frame(1'b0, 8'h3C, 1'b0, DIV_A);
    repeat (300) @(negedge clk);
    check("ferr_data_kept", {24'b0, data_a}, 32'hA5);
    check("ferr_busy", {31'b0, busy_a}, 32'd0);

    // Back-to-back frames with no idle time.
    send_frame(1'b0, 8'h00, 1'b1, DIV_A);
    send_frame(1'b0, 8'hFF, 1'b1, DIV_A);
    repeat (20) @(negedge clk);
    check("b2b_count", vt_a.size(), 32'd3);
    if (vt_a.size() == 3) check("b2b_gap", vt_a[2] - vt_a[1], 10 * DIV_A);
    check("b2b_data", {24'b0, data_a}, 32'hFF);

    // Reset in the middle of data bit 3, then a clean frame.
    pb = 8'h5A;
    rx_a = 1'b0;
    repeat (DIV_A) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_a = pb[i];
      repeat (DIV_A) @(negedge clk);
    end
    rx_a = pb[3];
    repeat (DIV_A / 2) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy_a}, 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("mid_rst_data",  {24'b0, data_a}, 32'h00);
    check("mid_rst_valid", {31'b0, valid_a}, 32'd0);
    check("mid_rst_ferr",  {31'b0, ferr_a}, 32'd0);
    check("mid_rst_busy",  {31'b0, busy_a}, 32'd0);
    last_good[0] = 8'h00;
    repeat (DIV_A / 2) @(negedge clk);
    rx_a = 1'b1;
    repeat (DIV_A) @(negedge clk);
    check("post_rst_busy", {31'b0, busy_a}, 32'd0);
    send_frame(1'b0, 8'h07, 1'b1, DIV_A);
    repeat (20) @(negedge clk);
    check("after_rst_data", {24'b0, data_a}, 32'h07);

    // Break on the short-divisor instance: two framing errors, then release
    // just after the second so the re-entered start is rejected.
    eb0.is_ferr = 1'b1;
    eb0.data    = last_good[1];
    eb0.t_fall  = cyc;
    q_b.push_back(eb0);
    eb0.t_fall  = -1;
    q_b.push_back(eb0);
    rx_b = 1'b0;
    repeat (310) @(negedge clk);
    rx_b = 1'b1;
    repeat (100) @(negedge clk);
    check("break_busy", {31'b0, busy_b}, 32'd0);

    // Transmitter-model loopback: repeating values 0..7, back to back.
    for (int v = 0; v < 8; v++) send_frame(1'b1, v[7:0], 1'b1, DIV_B);
    repeat (50) @(negedge clk);
    check("loop_data", {24'b0, data_b}, 32'h07);

    n = 0;
    while ((q_a.size() + q_b.size()) > 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain", q_a.size() + q_b.size(), 32'd0);
    check("cnt_valid_a", n_valid_a, 32'd4);
    check("cnt_ferr_a",  n_ferr_a,  32'd1);
    check("cnt_valid_b", n_valid_b, 32'd8);
    check("cnt_ferr_b",  n_ferr_b,  32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
